// File: rtl/output_stream_scheduler.sv
// Output stream scheduler: queues {size, groups} jobs, launches them one at a
// time to an output streamer via a level enable, snoops the streamer's
// AXI-stream handshake to detect completion or a stall, then holds the enable
// low for a short gap so the streamer can clear its counters.
module output_stream_scheduler #(
    parameter int MAX_ADDR_WIDTH = 13,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT        = 1024
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_areset,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [MAX_ADDR_WIDTH-1:0]       job_size,
    input  logic [3:0]                      job_groups,
    output logic                            start_output,
    output logic [MAX_ADDR_WIDTH-1:0]       out_size,
    output logic [3:0]                      groups,
    input  logic                            mon_tvalid,
    input  logic                            mon_tready,
    input  logic                            mon_tlast,
    output logic                            job_done,
    output logic                            job_err,
    output logic [MAX_ADDR_WIDTH-1:0]       done_beats,
    output logic                            busy,
    output logic [$clog2(QUEUE_DEPTH):0]    jobs_pending
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = MAX_ADDR_WIDTH + 4;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(QUEUE_DEPTH);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    // Job queue storage and bookkeeping
    logic [EW-1:0]             r_mem [QUEUE_DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic                      w_push;
    logic                      w_pop;
    logic [MAX_ADDR_WIDTH-1:0] w_head_size;
    logic [3:0]                w_head_groups;

    // Scheduler state
    state_t                    r_state;
    logic                      r_start;
    logic [MAX_ADDR_WIDTH-1:0] r_out_size;
    logic [3:0]                r_groups;
    logic                      r_job_done;
    logic                      r_job_err;
    logic [MAX_ADDR_WIDTH-1:0] r_done_beats;
    logic [TW-1:0]             r_idle_cnt;
    logic                      r_gap_cnt;
    logic                      w_hs;

    // Readiness depends on occupancy alone, so a pop never frees a slot for a
    // push in the same cycle.
    assign job_ready     = (r_count < DEPTH_C);
    assign w_push        = job_valid && job_ready;
    assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_size   = r_mem[r_rd_ptr][EW-1:4];
    assign w_head_groups = r_mem[r_rd_ptr][3:0];
    assign w_hs          = mon_tvalid && mon_tready;

    // Queue payload write; storage is not reset
    // NOTE: the data array needs no reset because the pointers and occupancy
    // define which entries are valid; resetting it only costs flops and muxes.
    always_ff @(posedge m_axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {job_size, job_groups};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at a power-of-two depth
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Job sequencing FSM with registered outputs
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_out_size   <= '0;
            r_groups     <= '0;
            r_job_done   <= 1'b0;
            r_job_err    <= 1'b0;
            r_done_beats <= '0;
            r_idle_cnt   <= '0;
            r_gap_cnt    <= 1'b0;
        end else begin
            r_job_done <= 1'b0;
            r_job_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_out_size   <= w_head_size;
                        r_groups     <= w_head_groups;
                        r_done_beats <= '0;
                        r_idle_cnt   <= '0;
                        if ((w_head_size == '0) || (w_head_groups == '0)) begin
                            // Degenerate job: report and discard without launching
                            r_job_done <= 1'b1;
                            r_job_err  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_idle_cnt <= '0;
                        if (r_done_beats != '1) begin
                            r_done_beats <= r_done_beats + MAX_ADDR_WIDTH'(1);
                        end
                        if (mon_tlast) begin
                            r_start    <= 1'b0;
                            r_job_done <= 1'b1;
                            r_gap_cnt  <= 1'b0;
                            r_state    <= S_GAP;
                        end else begin
                            r_start <= 1'b1;
                        end
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        // Streamer stalled too long: abort the job
                        r_start    <= 1'b0;
                        r_job_done <= 1'b1;
                        r_job_err  <= 1'b1;
                        r_gap_cnt  <= 1'b0;
                        r_state    <= S_GAP;
                    end else begin
                        r_start    <= 1'b1;
                        r_idle_cnt <= r_idle_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= 1'b1;
                    if (r_gap_cnt) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign start_output = r_start;
    assign out_size     = r_out_size;
    assign groups       = r_groups;
    assign job_done     = r_job_done;
    assign job_err      = r_job_err;
    assign done_beats   = r_done_beats;
    assign busy         = (r_state != S_IDLE);
    assign jobs_pending = r_count;

endmodule

// File: tb/tb_output_stream_scheduler.sv
// Directed testbench for output_stream_scheduler (QUEUE_DEPTH=4, TIMEOUT=16).
module tb_output_stream_scheduler;

    localparam int MAW = 13;

    logic           clk;
    logic           rst;
    logic           job_valid;
    logic           job_ready;
    logic [MAW-1:0] job_size;
    logic [3:0]     job_groups;
    logic           start_output;
    logic [MAW-1:0] out_size;
    logic [3:0]     groups;
    logic           mon_tvalid;
    logic           mon_tready;
    logic           mon_tlast;
    logic           job_done;
    logic           job_err;
    logic [MAW-1:0] done_beats;
    logic           busy;
    logic [2:0]     jobs_pending;

    int n_cmp = 0;
    int n_err = 0;

    output_stream_scheduler #(
        .MAX_ADDR_WIDTH (MAW),
        .QUEUE_DEPTH    (4),
        .TIMEOUT        (16)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_size      (job_size),
        .job_groups    (job_groups),
        .start_output  (start_output),
        .out_size      (out_size),
        .groups        (groups),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .mon_tlast     (mon_tlast),
        .job_done      (job_done),
        .job_err       (job_err),
        .done_beats    (done_beats),
        .busy          (busy),
        .jobs_pending  (jobs_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle past it before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int sz, input int gr);
        job_valid  = 1'b1;
        job_size   = MAW'(sz);
        job_groups = 4'(gr);
    endtask

    task automatic set_mon(input logic v, input logic r, input logic l);
        mon_tvalid = v;
        mon_tready = r;
        mon_tlast  = l;
    endtask

    // One tlast handshake ends the running job; then two GAP cycles to IDLE
    task automatic end_job(input string tag, input int beats_exp);
        set_mon(1'b1, 1'b1, 1'b1);
        tick();
        set_mon(1'b0, 1'b0, 1'b0);
        check({tag, "_done"},  job_done,     1);
        check({tag, "_err"},   job_err,      0);
        check({tag, "_beats"}, done_beats,   beats_exp);
        check({tag, "_start"}, start_output, 0);
        tick();
        tick();
        check({tag, "_idle"},  busy,         0);
    endtask

    initial begin
        rst = 1'b1;
        job_valid = 1'b0; job_size = '0; job_groups = '0;
        set_mon(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_start",   start_output, 0);
        check("rst_done",    job_done,     0);
        check("rst_busy",    busy,         0);
        check("rst_pending", jobs_pending, 0);
        check("rst_ready",   job_ready,    1);
        check("rst_size",    out_size,     0);
        rst = 1'b0;
        tick();

        // Basic job: size 12, groups 6, two beats
        offer(12, 6);
        tick();
        job_valid = 1'b0;
        check("b_pend1",  jobs_pending, 1);
        check("b_start0", start_output, 0);
        tick();
        check("b_busy",   busy,         1);
        check("b_start1", start_output, 0);
        check("b_pend0",  jobs_pending, 0);
        check("b_size",   out_size,     12);
        check("b_groups", groups,       6);
        tick();
        check("b_start2", start_output, 1);
        set_mon(1'b1, 1'b1, 1'b0);
        tick();
        check("b_nodone", job_done,     0);
        set_mon(1'b1, 1'b1, 1'b1);
        tick();
        set_mon(1'b0, 1'b0, 1'b0);
        check("b_done",   job_done,     1);
        check("b_err",    job_err,      0);
        check("b_beats",  done_beats,   2);
        check("b_stop",   start_output, 0);
        check("b_gap1",   busy,         1);
        tick();
        check("b_pulse",  job_done,     0);
        check("b_gap2",   busy,         1);
        check("b_hold",   out_size,     12);
        tick();
        check("b_idle",   busy,         0);

        // Zero-size job discarded, following job runs
        offer(0, 6);
        tick();
        offer(6, 6);
        tick();
        job_valid = 1'b0;
        check("z_done",   job_done,     1);
        check("z_err",    job_err,      1);
        check("z_beats",  done_beats,   0);
        check("z_busy",   busy,         0);
        check("z_start",  start_output, 0);
        check("z_pend",   jobs_pending, 1);
        tick();
        check("z2_busy",  busy,         1);
        check("z2_size",  out_size,     6);
        check("z2_nodone", job_done,    0);
        tick();
        check("z2_start", start_output, 1);
        end_job("z2", 1);

        // Timeout: RUN entry at edge E, abort visible after E+16
        offer(5, 2);
        tick();
        offer(7, 3);
        tick();
        job_valid = 1'b0;
        check("t_busy", busy, 1);
        for (int i = 0; i < 15; i++) tick();
        check("t_early",  job_done,     0);
        check("t_run",    start_output, 1);
        tick();
        check("t_done",   job_done,     1);
        check("t_err",    job_err,      1);
        check("t_beats",  done_beats,   0);
        check("t_start",  start_output, 0);
        // Handshakes during GAP and IDLE must be ignored
        set_mon(1'b1, 1'b1, 1'b1);
        tick();
        check("t_gapdone1", job_done,   0);
        check("t_gapbeats", done_beats, 0);
        tick();
        check("t_gapdone2", job_done,   0);
        check("t_gapsize",  out_size,   5);
        check("t_idle",     busy,       0);
        tick();
        set_mon(1'b0, 1'b0, 1'b0);
        check("t_ignore",   job_done,   0);
        check("t2_size",    out_size,   7);
        check("t2_groups",  groups,     3);
        check("t2_busy",    busy,       1);
        end_job("t2", 1);

        // Full queue: a job in RUN, then five back-to-back offers
        offer(3, 1);
        tick();
        offer(1, 1);
        tick();
        check("f_pend1", jobs_pending, 1);
        check("f_busy",  busy,         1);
        offer(2, 2);
        tick();
        check("f_pend2", jobs_pending, 2);
        offer(3, 3);
        tick();
        check("f_pend3", jobs_pending, 3);
        check("f_rdy3",  job_ready,    1);
        offer(4, 4);
        tick();
        check("f_pend4", jobs_pending, 4);
        check("f_rdy4",  job_ready,    0);
        offer(5, 5);
        tick();
        check("f_pend5", jobs_pending, 4);
        check("f_rdy5",  job_ready,    0);
        set_mon(1'b1, 1'b1, 1'b1);
        tick();
        set_mon(1'b0, 1'b0, 1'b0);
        check("f_adone", job_done,     1);
        check("f_abeat", done_beats,   1);
        tick();
        tick();
        check("f_idle",  busy,         0);
        check("f_pendi", jobs_pending, 4);
        tick();
        check("f_pop",   jobs_pending, 3);
        check("f_rdyp",  job_ready,    1);
        check("f_size1", out_size,     1);
        tick();
        job_valid = 1'b0;
        check("f_push5", jobs_pending, 4);
        check("f_start", start_output, 1);

        // Reset in RUN with jobs queued
        rst = 1'b1;
        tick();
        check("r_start",   start_output, 0);
        check("r_pend",    jobs_pending, 0);
        check("r_done",    job_done,     0);
        check("r_busy",    busy,         0);
        check("r_ready",   job_ready,    1);
        check("r_size",    out_size,     0);
        check("r_beats",   done_beats,   0);
        tick();
        check("r_done2",   job_done,     0);
        rst = 1'b0;
        tick();

        // FIFO order across wrap, with push and pop together at occupancy 2
        offer(9, 1);
        tick();
        offer(10, 2);
        tick();
        offer(11, 3);
        tick();
        job_valid = 1'b0;
        check("w_pend2",  jobs_pending, 2);
        check("w_size0",  out_size,     9);
        end_job("w0", 1);
        offer(13, 4);
        tick();
        job_valid = 1'b0;
        check("w_pp",     jobs_pending, 2);
        check("w_size1",  out_size,     10);
        check("w_grp1",   groups,       2);
        offer(14, 5);
        tick();
        job_valid = 1'b0;
        check("w_pend3",  jobs_pending, 3);
        end_job("w1", 1);
        tick();
        check("w_size2",  out_size,     11);
        check("w_grp2",   groups,       3);
        end_job("w2", 1);
        tick();
        check("w_size3",  out_size,     13);
        check("w_grp3",   groups,       4);
        end_job("w3", 1);
        tick();
        check("w_size4",  out_size,     14);
        check("w_grp4",   groups,       5);
        check("w_empty",  jobs_pending, 0);
        end_job("w4", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/output_stream_scheduler.md
OUTPUT_STREAM_SCHEDULER -- requirements
Module: output_stream_scheduler

Interface
REQ-001 Parameter MAX_ADDR_WIDTH, default 13: width of job size and beat counters.
REQ-002 Parameter QUEUE_DEPTH, default 4, power of two: job queue entries.
REQ-003 Parameter TIMEOUT, default 1024: idle cycles in RUN before a job is aborted.
REQ-004 m_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 m_axis_areset  in  1  synchronous, active-high reset.
REQ-006 job_valid  in  1  job offered.
REQ-007 job_ready  out  1  queue can accept a job.
REQ-008 job_size  in  MAX_ADDR_WIDTH  output element count of the job.
REQ-009 job_groups  in  4  elements packed per output beat.
REQ-010 start_output  out  1  level enable to the output streamer.
REQ-011 out_size  out  MAX_ADDR_WIDTH  size of the active job.
REQ-012 groups  out  4  groups of the active job.
REQ-013 mon_tvalid, mon_tready, mon_tlast  in  1 each  snoop of the streamer's AXI-stream handshake.
REQ-014 job_done  out  1  one-cycle pulse when a job finishes or is discarded.
REQ-015 job_err  out  1  qualifies job_done: job discarded or timed out.
REQ-016 done_beats  out  MAX_ADDR_WIDTH  beats handshaked in the finished job; valid with job_done.
REQ-017 busy  out  1  high whenever FSM is not IDLE.
REQ-018 jobs_pending  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.

Function
REQ-019 The queue SHALL be a FIFO of {job_size, job_groups}; push on job_valid && job_ready; job_ready = (occupancy < QUEUE_DEPTH), combinational from occupancy only.
REQ-020 Full queue: job_ready low; a pop in the same cycle does not enable a push that cycle.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-022 FSM states: IDLE, RUN, GAP.
REQ-023 IDLE, occupancy > 0: pop head into out_size/groups registers; if size or groups is 0, pulse job_done with job_err=1, done_beats=0, stay IDLE; else go to RUN and set start_output=1 next cycle.
REQ-024 Latency: job pushed into empty queue at edge N -> start_output high after edge N+2.
REQ-025 RUN: start_output held high; done_beats counter increments on each mon_tvalid && mon_tready; saturates at all-ones.
REQ-026 RUN: handshake with mon_tlast -> start_output=0, job_done=1, job_err=0, done_beats includes the last beat, go to GAP.
REQ-027 RUN: idle counter resets on each handshake, else increments; reaching TIMEOUT-1 -> start_output=0, job_done=1, job_err=1, go to GAP.
REQ-028 GAP: start_output low exactly 2 cycles so the streamer clears its counters, then IDLE; no pop in GAP.
REQ-029 out_size and groups SHALL be stable from pop through end of GAP.
REQ-030 Handshakes snooped outside RUN SHALL be ignored.
REQ-031 Job arriving while RUN SHALL only queue; it never alters the active job.

Reset
REQ-032 On m_axis_areset: FSM IDLE, queue flushed, occupancy 0, job_ready=1 next cycle, start_output/job_done/job_err/busy = 0, out_size/groups/done_beats = 0, counters cleared.
REQ-033 Reset asserted in RUN SHALL drop start_output the next cycle and never pulse job_done for the aborted job.

Verification
REQ-034 Push {size=12, groups=6}; stream 2 beats, tlast on 2nd -> start_output high 2 cycles after push, job_done with done_beats=2, job_err=0, 2 GAP cycles, busy low.
REQ-035 Push 5 jobs back-to-back with QUEUE_DEPTH=4 while mon_tvalid=0 -> 4 accepted, job_ready low on 5th until first pop, jobs_pending peaks at 4.
REQ-036 Push {size=0, groups=6} then {size=6, groups=6} -> first: job_done+job_err, no start_output; second runs normally.
REQ-037 Enter RUN, hold mon_tvalid=0 with TIMEOUT=16 -> job_done+job_err 16 cycles after RUN entry, start_output low, next job launches after GAP.
REQ-038 Assert reset mid-RUN with 2 jobs queued -> start_output low next cycle, jobs_pending=0, no job_done; post-reset push runs cleanly.
REQ-039 Push and pop in same cycle at occupancy 2 -> occupancy stays 2, FIFO order preserved across pointer wrap.
